// File: rtl/mem_responder_if.sv
// Request/response bus between a datapath master and mem_responder.
interface mem_responder_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
);
  logic                  req_valid;
  logic                  req_write;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  req_ready;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_rdata;

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/mem_responder.sv
// Word-addressed data memory with fixed wait states and a one-cycle response strobe.
// MEM_RDATA_HOLD_EN: when defined, rsp_rdata keeps the last response instead of returning to 0.
module mem_responder #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 8,
  parameter int WAIT_STATES = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  mem_responder_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_e;

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

  state_e                state_q;
  logic [3:0]            cnt_q;
  logic                  write_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  ready_q;
  logic                  rsp_valid_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [DATA_WIDTH-1:0] rdata_d;
  logic                  access;

  // Storage is deliberately outside the reset domain; zero only at time 0.
  logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH] = '{default: '0};

  assign access  = (state_q == S_WAIT) && (cnt_q == 4'd0);
  assign rdata_d = write_q ? wdata_q : mem_q[addr_q];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      write_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      ready_q     <= 1'b1;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.req_valid && ready_q) begin
            write_q <= bus.req_write;
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
            cnt_q   <= WAIT_INIT;
            ready_q <= 1'b0;
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            rdata_q     <= rdata_d;
            rsp_valid_q <= 1'b1;
            state_q     <= S_RESP;
          end
        end
        S_RESP: begin
          rsp_valid_q <= 1'b0;
          ready_q     <= 1'b1;
          state_q     <= S_IDLE;
`ifdef MEM_RDATA_HOLD_EN
          rdata_q     <= rdata_q;
`else
          rdata_q     <= '0;
`endif
        end
        default: begin
          state_q <= S_IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  // A write landing on a reset edge must be dropped, hence the rst_n qualifier.
  always_ff @(posedge clk) begin
    if (rst_n && access && write_q) begin
      mem_q[addr_q] <= wdata_q;
    end
  end

  assign bus.req_ready = ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rdata_q;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: a W=2 instance driven by directed and random
// transactions against an array model, plus a W=0 instance for back-to-back timing.
`timescale 1ns/1ps
module tb_mem_responder;

  localparam int DW = 32;
  localparam int AW = 8;
  localparam int W  = 2;
`ifdef MEM_RDATA_HOLD_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_responder_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus  ();
  mem_responder_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus0 ();

  mem_responder #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WAIT_STATES(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  mem_responder #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WAIT_STATES(0)) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0)
  );

  logic [DW-1:0] refMem [2**AW];
  int numChecks = 0;
  int numFails  = 0;

  task automatic checkOutput(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    numChecks++;
    assert (obs === exp) else begin
      numFails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One complete transaction; expectations come from the array model and the W+1 latency rule.
  task automatic applyStimulus(input bit wr, input logic [AW-1:0] addr,
                               input logic [DW-1:0] wd, output logic [DW-1:0] expData);
    int  k;
    int  readyLow;
    bit  seen;
    expData = wr ? wd : refMem[addr];
    @(negedge clk);
    checkOutput("ready_before_accept", 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_addr  = addr;
    bus.req_wdata = wd;
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_write = 1'($urandom);
    bus.req_addr  = AW'($urandom);
    bus.req_wdata = $urandom;
    k = 1;
    seen = 1'b0;
    readyLow = 0;
    while (!seen && k <= 40) begin
      if (!bus.req_ready) readyLow++;
      if (bus.rsp_valid) seen = 1'b1;
      else begin
        @(negedge clk);
        k++;
      end
    end
    checkOutput("rsp_latency", 32'(k), 32'(W + 2));
    checkOutput("rsp_rdata", bus.rsp_rdata, expData);
    if (wr) refMem[addr] = wd;
    @(negedge clk);
    checkOutput("rsp_one_cycle", 32'(bus.rsp_valid), 32'd0);
    checkOutput("ready_back", 32'(bus.req_ready), 32'd1);
    checkOutput("ready_low_cycles", 32'(readyLow), 32'(W + 2));
    checkOutput("rdata_after_resp", bus.rsp_rdata, HOLD ? expData : '0);
  endtask

  // Accept a write, then pull reset low so the edge after negedge rstAt sees rst_n=0.
  task automatic resetDuringWait(input logic [AW-1:0] addr, input logic [DW-1:0] wd, input int rstAt);
    bit sawRsp;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_addr  = addr;
    bus.req_wdata = wd;
    @(negedge clk);
    bus.req_valid = 1'b0;
    sawRsp = bus.rsp_valid;
    for (int n = 2; n <= rstAt; n++) begin
      @(negedge clk);
      sawRsp = sawRsp | bus.rsp_valid;
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checkOutput("reset_ready", 32'(bus.req_ready), 32'd1);
    checkOutput("reset_rdata", bus.rsp_rdata, '0);
    for (int n = 0; n < 6; n++) begin
      sawRsp = sawRsp | bus.rsp_valid;
      @(negedge clk);
    end
    checkOutput("reset_no_rsp", 32'(sawRsp), 32'd0);
  endtask

  initial begin
    logic [DW-1:0] got;
    int firstRsp;
    int secondRsp;
    int rspCount;
    bit readyAt3;

    for (int i = 0; i < 2**AW; i++) refMem[i] = '0;
    bus.req_valid  = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus0.req_valid = 1'b0;
    bus0.req_write = 1'b0;
    bus0.req_addr  = '0;
    bus0.req_wdata = '0;

    repeat (3) @(negedge clk);
    checkOutput("rst_ready", 32'(bus.req_ready), 32'd1);
    checkOutput("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    checkOutput("rst_rdata", bus.rsp_rdata, '0);
    rst_n = 1'b1;

    $display("[TB] read of unwritten address");
    applyStimulus(1'b0, 8'h05, '0, got);

    $display("[TB] write then read 0x10");
    applyStimulus(1'b1, 8'h10, 32'hDEADBEEF, got);
    applyStimulus(1'b0, 8'h10, '0, got);

    $display("[TB] random traffic");
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), AW'(8'h40 + $urandom_range(0, 3)), $urandom, got);
    end

    $display("[TB] reset during wait");
    resetDuringWait(8'h20, 32'h12345678, 1);
    applyStimulus(1'b0, 8'h20, '0, got);
    resetDuringWait(8'h21, 32'h0BADF00D, W + 1);
    applyStimulus(1'b0, 8'h21, '0, got);

    $display("[TB] read data hold");
    applyStimulus(1'b1, 8'h30, 32'hCAFEF00D, got);
    applyStimulus(1'b0, 8'h30, '0, got);
    for (int n = 0; n < 5; n++) begin
      checkOutput("hold_idle", bus.rsp_rdata, HOLD ? 32'hCAFEF00D : '0);
      @(negedge clk);
    end

    $display("[TB] top address");
    applyStimulus(1'b1, 8'hFF, 32'hA5A55A5A, got);
    applyStimulus(1'b0, 8'hFF, '0, got);
    applyStimulus(1'b0, 8'h00, '0, got);

    $display("[TB] zero wait states, valid held high");
    @(negedge clk);
    bus0.req_valid = 1'b1;
    bus0.req_write = 1'b0;
    bus0.req_addr  = 8'h01;
    firstRsp  = 0;
    secondRsp = 0;
    rspCount  = 0;
    readyAt3  = 1'b0;
    for (int n = 1; n <= 6; n++) begin
      @(negedge clk);
      if (n == 1) bus0.req_addr = 8'h02;
      if (n == 3) readyAt3 = bus0.req_ready;
      if (bus0.rsp_valid) begin
        rspCount++;
        if (rspCount == 1) firstRsp = n;
        if (rspCount == 2) secondRsp = n;
        checkOutput("w0_rdata", bus0.rsp_rdata, '0);
      end
      if (n == 6) bus0.req_valid = 1'b0;
    end
    checkOutput("w0_first_rsp", 32'(firstRsp), 32'd2);
    checkOutput("w0_second_rsp", 32'(secondRsp), 32'd5);
    checkOutput("w0_rsp_count", 32'(rspCount), 32'd2);
    checkOutput("w0_ready_reaccept", 32'(readyAt3), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
# mem_responder

Word-addressed data-memory responder for the multicycle datapath. Accepts single read or write requests through a valid/ready handshake, inserts a fixed number of wait states, and returns read data with a one-cycle response strobe. Its `rsp_rdata` output drives the memory data register, which samples it on every clock edge.

## Interface
- `DATA_WIDTH`, default 32: word width in bits.
- `ADDR_WIDTH`, default 8: word-address width; depth is 2^ADDR_WIDTH words.
- `WAIT_STATES`, default 2: extra cycles between accept and access; legal range 0..15.

Ports:
- `clk`  in  1  single clock; all state changes on rising edge.
- `rst_n`  in  1  synchronous, active-low reset, sampled on rising edge of `clk`.
- `req_valid`  in  1  request present.
- `req_write`  in  1  1 = write, 0 = read; sampled on accept.
- `req_addr`  in  ADDR_WIDTH  word address; sampled on accept.
- `req_wdata`  in  DATA_WIDTH  write data; sampled on accept.
- `req_ready`  out  1  responder can accept; high only in IDLE.
- `rsp_valid`  out  1  one-cycle response strobe.
- `rsp_rdata`  out  DATA_WIDTH  read data (write data echoed for writes).

## Operation
- Reset values: state IDLE, `req_ready`=1, `rsp_valid`=0, `rsp_rdata`=0, wait counter 0, request latches 0.
- Memory array is not touched by reset. It is zero-initialised at time 0 for simulation.
- Accept occurs when `req_valid`&&`req_ready` at a rising edge. On accept:
  - latch `req_write`, `req_addr` and `req_wdata`;
  - load counter with WAIT_STATES;
  - go to WAIT.
- WAIT state:
  - `req_ready`=0.
  - At each edge, if counter≠0, decrement it.
  - If counter==0, perform the access and go to RESP.
- Access, read: `rsp_rdata` ← mem[addr].
- Access, write: mem[addr] ← wdata and `rsp_rdata` ← wdata.
- RESP state:
  - `rsp_valid`=1 and `req_ready`=0.
  - Unconditionally go to IDLE on the next edge. There is no back-pressure on responses.
- Inputs are ignored outside IDLE. `req_valid` held high across a response is accepted again once back in IDLE.
- Counter is 4 bits. It never wraps because it only decrements from a nonzero value.
- Read-after-write to the same address returns the new data, because the write commits before any later access.

## Timing
- Accept at edge E0 → access at edge E0+WAIT_STATES+1 → `rsp_valid` high for exactly the cycle between edges E0+W+1 and E0+W+2.
- Back in IDLE after edge E0+W+2. The earliest next accept is edge E0+W+3, so throughput is one request per W+3 cycles.
- WAIT_STATES=0: the response is visible one cycle after accept.
- Reset priority: `rst_n`=0 at any edge overrides every transition.
  - A write whose access edge coincides with reset is dropped; memory is unchanged.
  - Reset during WAIT abandons the request. No `rsp_valid` is produced.
- Reset deasserted with `req_valid`=1: accept occurs at the first edge with `rst_n`=1.

## Configuration
- Macro `MEM_RDATA_HOLD_EN`.
- Defined: `rsp_rdata` holds the last response value until the next access, or until reset clears it to 0. The memory data register may sample late.
- Undefined: `rsp_rdata` is forced to 0 in every cycle where `rsp_valid`=0. It carries data only during the RESP cycle.
- Handshake timing is identical in both builds.

## Test plan
- Reset, then read of unwritten address 0x05 with W=2:
  - response rises 3 cycles after accept and lasts 1 cycle;
  - `rsp_rdata`=0;
  - `req_ready` is low for 4 cycles.
- Write 0xDEADBEEF to 0x10, then read 0x10:
  - write response echoes 0xDEADBEEF;
  - read returns 0xDEADBEEF;
  - second accept occurs no earlier than 5 edges after the first (W=2).
- W=0 build, back-to-back reads of 0x01 then 0x02 with `req_valid` held high:
  - accepts 3 cycles apart;
  - each `rsp_valid` one cycle after its accept.
- `rst_n` pulsed low during WAIT of a write of 0x12345678 to 0x20:
  - no `rsp_valid`;
  - a subsequent read of 0x20 returns the prior content 0.
- Hold check after reading 0xCAFEF00D:
  - with `MEM_RDATA_HOLD_EN` defined, `rsp_rdata` stays 0xCAFEF00D for 5 idle cycles;
  - without it, `rsp_rdata`=0 from the cycle after RESP.
- Address wrap, ADDR_WIDTH=8:
  - write to 0xFF, then read 0xFF returns the data;
  - address 0x00 is unchanged.
